// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: four-requester round-robin arbiter that drives the {A,B}
// index and EN inputs of a downstream 2-to-4 enabled decoder. Every output
// is taken directly from a flop, so the decoder select lines do not glitch.
// Optional feature macro: RR_SEL_ARBITER_GAP_EN inserts one dead (en=0)
// cycle after every grant, giving break-before-make on the decoder outputs.
module rr_sel_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic       sel_a,
    output logic       sel_b,
    output logic       en,
    output logic       timeout
);

    // The hold limit is compared against the 8-bit hold counter.
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

`ifdef RR_SEL_ARBITER_GAP_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1
    } state_t;
`endif

    state_t     state_reg, state_next;
    logic [1:0] ptr_reg, ptr_next;
    logic [1:0] idx_reg, idx_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       en_reg, en_next;
    logic       timeout_reg, timeout_next;
    logic       release_now;

    // Rotated candidate list: slot gi holds index ptr+1+gi (mod 4), so slot 3
    // is the last holder itself and it only wins when nobody else requests.
    logic [1:0] cand_idx [4];
    logic [3:0] cand_hit;
    logic [1:0] win_idx;
    logic       win_valid;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cand
            assign cand_idx[gi] = ptr_reg + 2'(gi + 1);
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Pick the first requesting candidate in rotation order.
    always_comb begin
        win_valid = |cand_hit;
        win_idx   = cand_idx[3];
        for (int i = 3; i >= 0; i--) begin
            if (cand_hit[i]) begin
                win_idx = cand_idx[i];
            end
        end
    end

    // Next-state, grant bookkeeping and registered-output inputs.
    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        idx_next     = idx_reg;
        cnt_next     = cnt_reg;
        timeout_next = 1'b0;
        release_now  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (win_valid) begin
                    state_next = GRANT;
                    idx_next   = win_idx;
                    ptr_next   = win_idx;
                    cnt_next   = 8'd1;
                end
            end

            GRANT: begin
                // A dropped request takes precedence over the hold limit, so a
                // simultaneous drop and limit is a plain release without timeout.
                if (!req[idx_reg]) begin
                    release_now = 1'b1;
                end else if (cnt_reg == HOLD_LIMIT) begin
                    release_now  = 1'b1;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end

                if (release_now) begin
`ifdef RR_SEL_ARBITER_GAP_EN
                    state_next = GAP;
                    cnt_next   = 8'd0;
`else
                    // Hand over in the same edge; en stays high across the switch.
                    if (win_valid) begin
                        idx_next = win_idx;
                        ptr_next = win_idx;
                        cnt_next = 8'd1;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = 8'd0;
                    end
`endif
                end
            end

`ifdef RR_SEL_ARBITER_GAP_EN
            GAP: begin
                // Dead cycle is over: arbitrate on the requests seen now.
                if (win_valid) begin
                    state_next = GRANT;
                    idx_next   = win_idx;
                    ptr_next   = win_idx;
                    cnt_next   = 8'd1;
                end else begin
                    state_next = IDLE;
                end
            end
`endif

            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase

        en_next = (state_next == GRANT);
    end

    // State and output registers; reset drops en immediately, without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= 2'd3;
            idx_reg     <= 2'd0;
            cnt_reg     <= 8'd0;
            en_reg      <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            idx_reg     <= idx_next;
            cnt_reg     <= cnt_next;
            en_reg      <= en_next;
            timeout_reg <= timeout_next;
        end
    end

    // The index register only changes on a new grant, so sel holds while en=0.
    assign sel_a   = idx_reg[1];
    assign sel_b   = idx_reg[0];
    assign en      = en_reg;
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb_rr_sel_arbiter: directed self-checking bench for rr_sel_arbiter.
// Four instances share clk/rst_n/req and differ only in MAX_HOLD
// (index 0: 8, 1: 2, 2: 1, 3: 3). Outputs are sampled 1 time unit after
// the rising edge; inputs are changed at the same point.
module tb_rr_sel_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] sa, sb, en_o, to_o;

    int checks;
    int errors;

    rr_sel_arbiter #(.MAX_HOLD(8)) u_h8 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .sel_a(sa[0]), .sel_b(sb[0]), .en(en_o[0]), .timeout(to_o[0])
    );
    rr_sel_arbiter #(.MAX_HOLD(2)) u_h2 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .sel_a(sa[1]), .sel_b(sb[1]), .en(en_o[1]), .timeout(to_o[1])
    );
    rr_sel_arbiter #(.MAX_HOLD(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .sel_a(sa[2]), .sel_b(sb[2]), .en(en_o[2]), .timeout(to_o[2])
    );
    rr_sel_arbiter #(.MAX_HOLD(3)) u_h3 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .sel_a(sa[3]), .sel_b(sb[3]), .en(en_o[3]), .timeout(to_o[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Reset values, even with every request high while reset is held.
    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({en_o[k], sa[k], sb[k], to_o[k]} !== 4'b0000) begin
                errors++;
                $display("FAIL reset inst%0d: {en,sel_a,sel_b,timeout}=%b want 0000",
                         k, {en_o[k], sa[k], sb[k], to_o[k]});
            end
        end
        req   = 4'b0000;
        tick();
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    // MAX_HOLD=8, single requester 0: 8 cycles of en, timeout, immediate re-grant.
    task automatic test_timeout_hold();
        do_reset();
        req = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if ({en_o[0], sa[0], sb[0], to_o[0]} !== 4'b1000) begin
                errors++;
                $display("FAIL hold8 cyc%0d: {en,sel,timeout}=%b want 1000",
                         k, {en_o[0], sa[0], sb[0], to_o[0]});
            end
        end
        tick();
        checks++;
        if ({en_o[0], sa[0], sb[0], to_o[0]} !== 4'b1001) begin
            errors++;
            $display("FAIL hold8 timeout: {en,sel,timeout}=%b want 1001",
                     {en_o[0], sa[0], sb[0], to_o[0]});
        end
        tick();
        checks++;
        if ({en_o[0], to_o[0]} !== 2'b10) begin
            errors++;
            $display("FAIL hold8 after: {en,timeout}=%b want 10", {en_o[0], to_o[0]});
        end
        $display("test_timeout_hold done");
    endtask

    // MAX_HOLD=2, all requesting: 0,0,1,1,2,2,3,3,0 with timeout at each change.
    task automatic test_rotation();
        logic [1:0] exp_idx [9];
        logic       exp_to  [9];
        exp_idx = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        exp_to  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            tick();
            checks++;
            if ({en_o[1], sa[1], sb[1], to_o[1]} !== {1'b1, exp_idx[k], exp_to[k]}) begin
                errors++;
                $display("FAIL rot2 cyc%0d: {en,sel,timeout}=%b want %b",
                         k, {en_o[1], sa[1], sb[1], to_o[1]}, {1'b1, exp_idx[k], exp_to[k]});
            end
        end
        $display("test_rotation done");
    endtask

    // MAX_HOLD=1, all requesting: index steps every cycle, timeout continuous.
    task automatic test_hold1();
        logic [1:0] exp_idx [6];
        logic       exp_to  [6];
        exp_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        exp_to  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if ({en_o[2], sa[2], sb[2], to_o[2]} !== {1'b1, exp_idx[k], exp_to[k]}) begin
                errors++;
                $display("FAIL hold1 cyc%0d: {en,sel,timeout}=%b want %b",
                         k, {en_o[2], sa[2], sb[2], to_o[2]}, {1'b1, exp_idx[k], exp_to[k]});
            end
        end
        $display("test_hold1 done");
    endtask

    // Grant 2, then drop req[2] with req=1001: rotation after 2 picks 3.
    task automatic test_release_rotation();
        do_reset();
        req = 4'b0100;
        tick();
        checks++;
        if ({en_o[0], sa[0], sb[0]} !== 3'b110) begin
            errors++;
            $display("FAIL rel grant2: {en,sel}=%b want 110", {en_o[0], sa[0], sb[0]});
        end
        req = 4'b1001;
        tick();
        checks++;
        if ({en_o[0], sa[0], sb[0], to_o[0]} !== 4'b1110) begin
            errors++;
            $display("FAIL rel next3: {en,sel,timeout}=%b want 1110",
                     {en_o[0], sa[0], sb[0], to_o[0]});
        end
        $display("test_release_rotation done");
    endtask

    // Reset between edges kills the grant at once; afterwards index 0 leads.
    task automatic test_async_reset();
        do_reset();
        req = 4'b1000;
        tick();
        checks++;
        if ({en_o[0], sa[0], sb[0]} !== 3'b111) begin
            errors++;
            $display("FAIL arst grant3: {en,sel}=%b want 111", {en_o[0], sa[0], sb[0]});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({en_o[0], sa[0], sb[0]} !== 3'b000) begin
            errors++;
            $display("FAIL arst immediate: {en,sel}=%b want 000", {en_o[0], sa[0], sb[0]});
        end
        req = 4'b0110;
        #2;
        rst_n = 1'b1;
        tick();
        checks++;
        if ({en_o[0], sa[0], sb[0], to_o[0]} !== 4'b1010) begin
            errors++;
            $display("FAIL arst first1: {en,sel,timeout}=%b want 1010",
                     {en_o[0], sa[0], sb[0], to_o[0]});
        end
        $display("test_async_reset done");
    endtask

    // MAX_HOLD=3: request drops on the edge where the limit is reached.
    task automatic test_drop_at_timeout();
        do_reset();
        req = 4'b0100;
        repeat (3) tick();
        checks++;
        if ({en_o[3], sa[3], sb[3]} !== 3'b110) begin
            errors++;
            $display("FAIL drop held: {en,sel}=%b want 110", {en_o[3], sa[3], sb[3]});
        end
        req = 4'b0000;
        tick();
        checks++;
        if ({en_o[3], sa[3], sb[3], to_o[3]} !== 4'b0100) begin
            errors++;
            $display("FAIL drop release: {en,sel,timeout}=%b want 0100",
                     {en_o[3], sa[3], sb[3], to_o[3]});
        end
        repeat (2) tick();
        checks++;
        if ({en_o[3], sa[3], sb[3], to_o[3]} !== 4'b0100) begin
            errors++;
            $display("FAIL drop idle: {en,sel,timeout}=%b want 0100",
                     {en_o[3], sa[3], sb[3], to_o[3]});
        end
        $display("test_drop_at_timeout done");
    endtask

`ifdef RR_SEL_ARBITER_GAP_EN
    // MAX_HOLD=3, req=0011: en 1,1,1,0,1,1,1,0 with idx 0 then 1, timeout in gaps.
    task automatic test_gap();
        logic       exp_en  [8];
        logic [1:0] exp_idx [8];
        logic       exp_to  [8];
        exp_en  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_idx = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
        exp_to  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        req = 4'b0011;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if ({en_o[3], sa[3], sb[3], to_o[3]} !== {exp_en[k], exp_idx[k], exp_to[k]}) begin
                errors++;
                $display("FAIL gap cyc%0d: {en,sel,timeout}=%b want %b",
                         k, {en_o[3], sa[3], sb[3], to_o[3]},
                         {exp_en[k], exp_idx[k], exp_to[k]});
            end
        end
        $display("test_gap done");
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = 4'b0000;
        test_reset();
`ifdef RR_SEL_ARBITER_GAP_EN
        test_async_reset();
        test_drop_at_timeout();
        test_gap();
`else
        test_timeout_hold();
        test_rotation();
        test_hold1();
        test_release_rotation();
        test_async_reset();
        test_drop_at_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_sel_arbiter.md
# rr_sel_arbiter

Four-requester round-robin arbiter producing the `{A,B}` index and `EN` inputs of the downstream 2-to-4 enabled decoder, which turns them into the one-hot grant/select vector. It owns all sequencing: fair rotation, grant hold, a hold-time limit, and an optional dead cycle between grants. All outputs are registered so the decoder sees glitch-free select lines.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one requester may hold `en`; legal range 1..255; the hold counter is 8 bits wide.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req` input 4: request vector; `req[i]` requests index i; level-sensitive, synchronous to `clk`.
- `sel_a` output 1: grant index bit 1 (MSB); drives decoder A.
- `sel_b` output 1: grant index bit 0 (LSB); drives decoder B.
- `en` output 1: grant valid; drives decoder EN.
- `timeout` output 1: one-cycle pulse when a grant ends because it reached `MAX_HOLD`.

## Operation
- Internal state:
  - `state` is IDLE, GRANT, or GAP (GAP exists only with the macro).
  - `ptr` (2 bits) holds the last granted index.
  - `idx` (2 bits) holds the current grant index.
  - `cnt` (8 bits) holds the cycles `en` has been high for the current grant.
- Rotation:
  - Candidates are checked in the order ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - The first index with `req` high wins.
  - The current holder is therefore eligible again only if no other index is requesting.
- IDLE behaviour:
  - `en`=0.
  - If any `req` bit is high: go to GRANT, set `idx`=winner, set `ptr`=winner, set `cnt`=1.
- GRANT behaviour: `en`=1, `{sel_a,sel_b}`=`idx`. Evaluated each edge in priority order:
  - `req[idx]`=0: release.
  - Otherwise, `cnt`==`MAX_HOLD`: release and pulse `timeout`.
  - Otherwise: `cnt`+1.
- Release without the macro:
  - Re-arbitrate in the same edge using the current `req`, excluding nothing.
  - If there is a winner: stay in GRANT, load the new `idx`/`ptr`, set `cnt`=1; `en` stays 1.
  - If there is no winner: go to IDLE.
- Release with the macro: go to GAP. See Configuration.
- `sel_a`/`sel_b` hold their last value whenever `en`=0.
- A decoded one-hot output is never driven from two indices in the same cycle.

## Timing
- Reset (asynchronous, immediate):
  - `en`=0, `sel_a`=0, `sel_b`=0, `timeout`=0.
  - State IDLE, `ptr`=3 (index 0 has first priority), `cnt`=0.
  - Reset asserted mid-grant drops `en` without waiting for a clock edge.
- Grant latency: `req` sampled high in IDLE -> `en`=1 with the index on the next cycle (1 cycle).
- Release latency: `req[idx]` sampled low at edge N -> `en` low, or the new index, from cycle N+1.
- Timeout: with `req[idx]` held, `en` is high for exactly `MAX_HOLD` cycles for that index. `timeout` is high for 1 cycle, aligned with the first cycle after the grant (the cycle `en` falls or the new grant starts).
- `MAX_HOLD`=1: every grant lasts one cycle. With all four `req` held, `idx` steps 0,1,2,3,0,... every cycle, and `timeout` is high continuously.
- `req` changes on non-holder bits during GRANT do not affect the current grant.
- A simultaneous timeout and `req[idx]` drop is treated as a release: no `timeout` pulse.

## Configuration
- Macro: `RR_SEL_ARBITER_GAP_EN`.
- Defined: every release enters GAP for exactly 1 cycle.
  - In GAP: `en`=0 and `sel` holds.
  - Arbitration uses `req` sampled at the end of the GAP cycle. Winner -> GRANT; none -> IDLE.
  - Back-to-back grants are separated by one `en`=0 cycle, giving break-before-make on the decoder outputs.
  - `timeout` is aligned with the GAP cycle.
- Undefined: no GAP state; releases re-arbitrate directly as described in Operation.

## Test plan
- Reset then `req`=0001 -> `en`=1, sel=00 one cycle later. Hold `req` with `MAX_HOLD`=8 -> `en` high 8 cycles, `timeout` pulse, then index 0 re-granted immediately (no macro).
- `req`=1111 held, `MAX_HOLD`=2 -> grant sequence 0,0,1,1,2,2,3,3,0 with a `timeout` pulse at each index change.
- Grant index 2, then drop `req[2]` while `req`=1001 -> next grant is index 3 (rotation after ptr=2), `timeout`=0.
- Assert `rst_n`=0 mid-grant (between edges) -> `en`, `sel_a`, `sel_b` go 0 immediately; after release, `req`=0110 -> index 1 is granted first.
- With `RR_SEL_ARBITER_GAP_EN`: `req`=0011, `MAX_HOLD`=3 -> `en` pattern 1,1,1,0,1,1,1,0 with idx 0 then 1, and `timeout` high in each `en`=0 cycle.
- `req`=0100 dropped on the same edge that `cnt`==`MAX_HOLD` -> `en` falls, `timeout` stays 0, state returns to IDLE.
